// File: rtl/iir_deemph.sv
// iir_deemph: FM de-emphasis stage. A first-order quantized IIR placed between
// the decimating audio FIR output FIFO and the gain/audio output FIFO.
// One multiply-accumulate per cycle; one sample in flight at a time.
// Optional build macro IIR_SAT_EN: clamp the result to signed 16 bits before it
// is written out and fed back. Without it the 32-bit accumulator wraps freely.
// DATA_WIDTH is also the accumulator/product truncation width (32 by default).
module iir_deemph #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS = 2,
  parameter int BITS = 10,
  // Coefficient k lives at bits [(TAPS-1-k)*32 +: 32], so the leftmost entry is index 0.
  parameter logic [TAPS*32-1:0] XC = {32'sd178, 32'sd178},
  parameter logic [TAPS*32-1:0] YC = {32'sd0, 32'hFFFF_FD66}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  x_empty,
  output logic                  x_rd_en,
  output logic [DATA_WIDTH-1:0] y_out,
  input  logic                  y_out_full,
  output logic                  y_wr_en
);

  localparam int KW = $clog2(2 * TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(2 * TAPS - 2);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(32'sd32767);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(-32'sd32768);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                        state_r;
  logic signed [DATA_WIDTH-1:0]  x_hist_r [TAPS];
  logic signed [DATA_WIDTH-1:0]  y_hist_r [TAPS-1];
  logic signed [DATA_WIDTH-1:0]  acc_r;
  logic        [KW-1:0]          k_r;
  logic        [DATA_WIDTH-1:0]  y_out_r;

  logic signed [31:0]            coef_s;
  logic signed [DATA_WIDTH-1:0]  samp_s;
  logic signed [DATA_WIDTH-1:0]  prod_s;
  logic signed [DATA_WIDTH-1:0]  deq_s;
  logic signed [DATA_WIDTH-1:0]  acc_sum_s;

  // Value that leaves the block and enters the feedback history.
  function automatic logic signed [DATA_WIDTH-1:0] out_value(input logic signed [DATA_WIDTH-1:0] v);
`ifdef IIR_SAT_EN
    if (v > SAT_MAX) begin
      return SAT_MAX;
    end else if (v < SAT_MIN) begin
      return SAT_MIN;
    end else begin
      return v;
    end
`else
    return v;
`endif
  endfunction

  // Select coefficient/sample pair for MAC step k: feed-forward taps first, then feedback taps.
  always_comb begin
    coef_s = '0;
    samp_s = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (k_r == KW'(i)) begin
        coef_s = XC[(TAPS-1-i)*32 +: 32];
        samp_s = x_hist_r[i];
      end else begin
        coef_s = coef_s;
      end
    end
    for (int j = 1; j < TAPS; j++) begin
      if (k_r == KW'(TAPS + j - 1)) begin
        coef_s = YC[(TAPS-1-j)*32 +: 32];
        samp_s = y_hist_r[j-1];
      end else begin
        coef_s = coef_s;
      end
    end
  end

  // Truncated product, arithmetic-shift dequantization (floors toward -inf), wrapping add.
  always_comb begin
    prod_s    = DATA_WIDTH'(coef_s) * samp_s;
    deq_s     = prod_s >>> BITS;
    acc_sum_s = acc_r + deq_s;
  end

  assign x_rd_en = reset && (state_r == S_READ) && !x_empty;
  assign y_wr_en = reset && (state_r == S_WRITE) && !y_out_full;
  assign y_out   = y_out_r;

  // Read / multiply-accumulate / write sequencer with history and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_READ;
      acc_r   <= '0;
      k_r     <= '0;
      y_out_r <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_hist_r[i] <= '0;
      end
      for (int i = 0; i < TAPS - 1; i++) begin
        y_hist_r[i] <= '0;
      end
    end else begin
      case (state_r)
        S_READ: begin
          if (!x_empty) begin
            x_hist_r[0] <= x_in;
            for (int i = 1; i < TAPS; i++) begin
              x_hist_r[i] <= x_hist_r[i-1];
            end
            acc_r   <= '0;
            k_r     <= '0;
            state_r <= S_MAC;
          end else begin
            state_r <= S_READ;
          end
        end
        S_MAC: begin
          acc_r <= acc_sum_s;
          if (k_r == K_LAST) begin
            // Output register is loaded with the final sum so it is stable while y_wr_en is high.
            y_out_r <= out_value(acc_sum_s);
            state_r <= S_WRITE;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        S_WRITE: begin
          if (!y_out_full) begin
            y_hist_r[0] <= y_out_r;
            for (int i = 1; i < TAPS - 1; i++) begin
              y_hist_r[i] <= y_hist_r[i-1];
            end
            state_r <= S_READ;
          end else begin
            state_r <= S_WRITE;
          end
        end
        default: begin
          state_r <= S_READ;
          k_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_deemph.sv
// Self-checking bench for iir_deemph: a source queue models the input FIFO,
// an independent reference recurrence fills a scoreboard at every pop, and
// every push is compared against the oldest scoreboard entry.
module tb_iir_deemph;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] x_in;
  logic        x_empty;
  logic        x_rd_en;
  logic [31:0] y_out;
  logic        y_out_full;
  logic        y_wr_en;

  always #5 clock = ~clock;

  iir_deemph dut (
    .clock(clock),
    .reset(reset),
    .x_in(x_in),
    .x_empty(x_empty),
    .x_rd_en(x_rd_en),
    .y_out(y_out),
    .y_out_full(y_out_full),
    .y_wr_en(y_wr_en)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int src_q[$];
  int exp_q[$];
  int got_q[$];
  int m_x0, m_x1, m_y0;
  bit starve = 1'b0;
  bit bp = 1'b0;
  bit check_interval = 1'b0;
  int cyc = 0;
  int pops = 0;
  int pushes = 0;
  int last_push_cyc = 0;
  int imp_exp[3];
  int sat_exp;
  int p0, q0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic int deq(input longint p);
    int t;
    t = p[31:0];
    return t >>> 10;
  endfunction

  function automatic int sat_model(input int v);
`ifdef IIR_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  task automatic model_push(input int x);
    int acc;
    int y;
    m_x1 = m_x0;
    m_x0 = x;
    acc = deq(longint'(178) * longint'(m_x0)) + deq(longint'(178) * longint'(m_x1))
        + deq(longint'(-666) * longint'(m_y0));
    y = sat_model(acc);
    m_y0 = y;
    exp_q.push_back(y);
  endtask

  task automatic model_reset();
    m_x0 = 0;
    m_x1 = 0;
    m_y0 = 0;
    exp_q.delete();
    src_q.delete();
  endtask

  task automatic drive();
    x_empty    = starve || (src_q.size() == 0);
    x_in       = (src_q.size() > 0) ? src_q[0] : 32'd0;
    y_out_full = bp;
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (x_rd_en || y_wr_en) check_val("pop_push_exclusive", {31'd0, x_rd_en & y_wr_en}, 32'd0);
    if (y_wr_en) begin
      pushes++;
      if (check_interval && last_push_cyc > 0) check_val("push_interval", cyc - last_push_cyc, 32'd5);
      last_push_cyc = cyc;
      got_q.push_back(y_out);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL stray_push: got %0d expected no push", $signed(y_out));
      end else begin
        check_val("y_out", y_out, exp_q.pop_front());
      end
    end
    if (x_rd_en) begin
      pops++;
      if (src_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL pop_when_empty: got x_rd_en=1 expected 0");
      end else begin
        model_push(src_q[0]);
        void'(src_q.pop_front());
      end
    end
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (src_q.size() == 0 && exp_q.size() == 0) break;
      tick();
    end
    check_val("drain_done", exp_q.size() + src_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    src_q.push_back(5);
    drive();
    #2;
    check_val("reset_x_rd_en", {31'd0, x_rd_en}, 32'd0);
    check_val("reset_y_wr_en", {31'd0, y_wr_en}, 32'd0);
    check_val("reset_y_out", y_out, 32'd0);
    src_q.delete();
    drive();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic run_impulse(input string tag);
    got_q.delete();
    src_q.push_back(1024);
    src_q.push_back(0);
    src_q.push_back(0);
    drive();
    drain(100);
    for (int i = 0; i < 3; i++)
      check_val(tag, (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, imp_exp[i]);
  endtask

  initial begin
    imp_exp[0] = 178;
    imp_exp[1] = 62;
    imp_exp[2] = -41;
`ifdef IIR_SAT_EN
    sat_exp = 32767;
`else
    sat_exp = 69531;
`endif
    reset = 1'b0;
    x_in = 32'd0;
    x_empty = 1'b1;
    y_out_full = 1'b0;
    @(posedge clock);
    #1;

    // Reset state and impulse response
    do_reset();
    run_impulse("impulse");

    // Back-pressure: stall in write for 10 cycles
    bp = 1'b1;
    src_q.push_back(300);
    src_q.push_back(-500);
    drive();
    p0 = pops;
    q0 = pushes;
    repeat (5) tick();
    repeat (10) tick();
    check_val("bp_no_push", pushes - q0, 32'd0);
    check_val("bp_no_extra_pop", pops - p0, 32'd1);
    bp = 1'b0;
    drive();
    tick();
    check_val("bp_one_push", pushes - q0, 32'd1);
    drain(100);
    check_val("bp_total_pops", pops - p0, 32'd2);

    // Starvation
    starve = 1'b1;
    src_q.push_back(777);
    drive();
    p0 = pops;
    q0 = pushes;
    repeat (20) tick();
    check_val("starve_no_pop", pops - p0, 32'd0);
    check_val("starve_no_push", pushes - q0, 32'd0);
    starve = 1'b0;
    drive();
    drain(100);
    check_val("starve_resume_push", pushes - q0, 32'd1);

    // Saturation / wide result from reset
    do_reset();
    got_q.delete();
    src_q.push_back(400000);
    drive();
    drain(100);
    check_val("sat_value", (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF, sat_exp);

    // Reset mid-MAC: in-flight sample discarded, then impulse again
    do_reset();
    src_q.push_back(1024);
    src_q.push_back(0);
    src_q.push_back(0);
    drive();
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    drive();
    q0 = pushes;
    repeat (3) tick();
    check_val("midreset_no_push", pushes - q0, 32'd0);
    reset = 1'b1;
    drive();
    run_impulse("impulse_after_reset");

    // Throughput with random samples
    do_reset();
    q0 = pushes;
    for (int i = 0; i < 1000; i++) src_q.push_back(int'($urandom));
    drive();
    check_interval = 1'b1;
    last_push_cyc = 0;
    drain(6000);
    check_interval = 1'b0;
    check_val("throughput_pushes", pushes - q0, 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
